// File: rtl/omp_pkg.sv
// Shared types and helpers for the OMP atom-selection stage: default widths,
// selector FSM states and a saturating absolute value.
package omp_pkg;

    localparam int unsigned DATA_W_DEF   = 19;
    localparam int unsigned IDX_W_DEF    = 8;
    localparam int unsigned N_ATOMS_DEF  = 256;
    localparam int unsigned MAX_ITER_DEF = 8;
    localparam int unsigned CNT_W_DEF    = 4;
    localparam int unsigned ABS_W        = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // |x| for a w-bit signed value held sign-extended in ABS_W bits; the
    // most-negative w-bit value clips to the largest positive one.
    function automatic logic [ABS_W-1:0] sat_abs(input logic signed [ABS_W-1:0] x,
                                                 input int unsigned w);
        logic [ABS_W-1:0] lim;
        logic [ABS_W-1:0] r;
        lim = (ABS_W'(1) << (w - 1)) - ABS_W'(1);
        r   = x[ABS_W-1] ? $unsigned(-x) : $unsigned(x);
        if (r > lim) begin
            r = lim;
        end
        return r;
    endfunction

endpackage

// File: rtl/omp_support_cam.sv
// Support list for the atom selector: MAX_ITER index registers with a write
// port, a parallel "already selected" match and a readback mux.
import omp_pkg::*;

module omp_support_cam #(
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned MAX_ITER = MAX_ITER_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_slot,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [IDX_W-1:0] key,
    output logic             match,
    input  logic [CNT_W-1:0] rd_slot,
    output logic [IDX_W-1:0] rd_idx
);

    logic [IDX_W-1:0]    entries [MAX_ITER];
    logic [MAX_ITER-1:0] valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_ITER); i++) begin
                entries[i] <= '0;
            end
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(MAX_ITER); i++) begin
                if (wr_slot == CNT_W'(i)) begin
                    entries[i] <= wr_idx;
                    valid[i]   <= 1'b1;
                end
            end
        end
    end

    // Valid bits track slots below the count, so readback past the count is 0.
    always_comb begin
        match  = 1'b0;
        rd_idx = '0;
        for (int i = 0; i < int'(MAX_ITER); i++) begin
            if (valid[i] && (entries[i] == key)) begin
                match = 1'b1;
            end
            if (valid[i] && (rd_slot == CNT_W'(i))) begin
                rd_idx = entries[i];
            end
        end
    end

endmodule

// File: rtl/omp_atom_selector.sv
// OMP atom selector: per sweep picks the max-|corr| atom not yet in support
// and commits it. Define OMP_SELECTOR_THRESH_EN to add the thresh early-stop port.
import omp_pkg::*;

module omp_atom_selector #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned N_ATOMS  = N_ATOMS_DEF,
    parameter int unsigned MAX_ITER = MAX_ITER_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_support,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    output logic              sel_valid,
    output logic [IDX_W-1:0]  sel_idx,
    output logic [DATA_W-1:0] sel_mag,
    output logic              sel_none,
    output logic [CNT_W-1:0]  sel_slot,
    output logic [CNT_W-1:0]  support_cnt,
    output logic              support_full,
    input  logic [CNT_W-1:0]  rd_slot,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              busy
`ifdef OMP_SELECTOR_THRESH_EN
    ,
    input  logic [DATA_W-1:0] thresh
`endif
);

    if (CNT_W < $clog2(MAX_ITER + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for MAX_ITER");
    end

    state_t            state, state_nxt;
    logic              accept, match, eligible, cand, commit_ok, wr_en;
    logic [DATA_W-1:0] mag;
    logic              fin_valid;
    logic [IDX_W-1:0]  fin_idx;
    logic [DATA_W-1:0] fin_mag;

    logic              best_valid, best_valid_d;
    logic [IDX_W-1:0]  best_idx, best_idx_d;
    logic [DATA_W-1:0] best_mag, best_mag_d;
    logic              sel_valid_d, sel_none_d, full_d;
    logic [IDX_W-1:0]  sel_idx_d;
    logic [DATA_W-1:0] sel_mag_d;
    logic [CNT_W-1:0]  sel_slot_d, cnt_d;

    assign in_ready = (state == SCAN);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign mag      = DATA_W'(sat_abs(ABS_W'($signed(in_data)), DATA_W));
    assign eligible = !match && (32'(in_idx) < N_ATOMS);
    assign cand     = accept && eligible && (!best_valid || (mag > best_mag));

    // Running max including the current beat, so the last beat competes too.
    assign fin_valid = best_valid || cand;
    assign fin_idx   = cand ? in_idx : best_idx;
    assign fin_mag   = cand ? mag : best_mag;
`ifdef OMP_SELECTOR_THRESH_EN
    assign commit_ok = fin_valid && (fin_mag > thresh);
`else
    assign commit_ok = fin_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && !support_full) state_nxt = SCAN;
            SCAN:    if (accept && in_last) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_support) begin
            state_nxt = IDLE;
        end
    end

    // Next values for the running max, result registers and support count.
    always_comb begin
        best_valid_d = best_valid;
        best_idx_d   = best_idx;
        best_mag_d   = best_mag;
        sel_valid_d  = 1'b0;
        sel_idx_d    = sel_idx;
        sel_mag_d    = sel_mag;
        sel_none_d   = sel_none;
        sel_slot_d   = sel_slot;
        cnt_d        = support_cnt;
        full_d       = support_full;
        wr_en        = 1'b0;
        if (clear_support) begin
            best_valid_d = 1'b0;
            cnt_d        = '0;
            full_d       = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !support_full) best_valid_d = 1'b0;
                end
                SCAN: begin
                    if (accept) begin
                        best_valid_d = fin_valid;
                        best_idx_d   = fin_idx;
                        best_mag_d   = fin_mag;
                        if (in_last) begin
                            sel_valid_d = 1'b1;
                            sel_none_d  = !commit_ok;
                            sel_idx_d   = fin_valid ? fin_idx : '0;
                            sel_mag_d   = fin_valid ? fin_mag : '0;
                            sel_slot_d  = support_cnt;
                        end
                    end
                end
                COMMIT: begin
                    if (!sel_none) begin
                        wr_en  = 1'b1;
                        cnt_d  = support_cnt + CNT_W'(1);
                        full_d = (cnt_d == CNT_W'(MAX_ITER));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_valid   <= 1'b0;
            best_idx     <= '0;
            best_mag     <= '0;
            sel_valid    <= 1'b0;
            sel_idx      <= '0;
            sel_mag      <= '0;
            sel_none     <= 1'b0;
            sel_slot     <= '0;
            support_cnt  <= '0;
            support_full <= 1'b0;
        end else begin
            best_valid   <= best_valid_d;
            best_idx     <= best_idx_d;
            best_mag     <= best_mag_d;
            sel_valid    <= sel_valid_d;
            sel_idx      <= sel_idx_d;
            sel_mag      <= sel_mag_d;
            sel_none     <= sel_none_d;
            sel_slot     <= sel_slot_d;
            support_cnt  <= cnt_d;
            support_full <= full_d;
        end
    end

    omp_support_cam #(
        .IDX_W    (IDX_W),
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_cam (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_support),
        .wr_en   (wr_en),
        .wr_slot (support_cnt),
        .wr_idx  (sel_idx),
        .key     (in_idx),
        .match   (match),
        .rd_slot (rd_slot),
        .rd_idx  (rd_idx)
    );

endmodule

// File: tb/tb_omp_atom_selector.sv
// Scoreboard bench for omp_atom_selector; expected results are queued per
// sweep and checked by a monitor on each sel_valid pulse.
module tb_omp_atom_selector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear_support = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] in_data = '0;
    logic [7:0]  in_idx = '0;
    logic        in_last = 1'b0;
    logic        sel_valid;
    logic [7:0]  sel_idx;
    logic [18:0] sel_mag;
    logic        sel_none;
    logic [3:0]  sel_slot;
    logic [3:0]  support_cnt;
    logic        support_full;
    logic [3:0]  rd_slot = '0;
    logic [7:0]  rd_idx;
    logic        busy;
    logic [18:0] thresh = '0;

    typedef struct {
        logic [7:0]  idx;
        logic [18:0] mag;
        logic        none;
        logic [3:0]  slot;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ecnt  = 0;
    int   bd[8];
    int   bi[8];

    omp_atom_selector dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear_support (clear_support),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_idx        (in_idx),
        .in_last       (in_last),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .sel_mag       (sel_mag),
        .sel_none      (sel_none),
        .sel_slot      (sel_slot),
        .support_cnt   (support_cnt),
        .support_full  (support_full),
        .rd_slot       (rd_slot),
        .rd_idx        (rd_idx),
        .busy          (busy)
`ifdef OMP_SELECTOR_THRESH_EN
        ,
        .thresh        (thresh)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int mag, input logic none, input int slot);
        exp_t e;
        e.idx  = 8'(idx);
        e.mag  = 19'(mag);
        e.none = none;
        e.slot = 4'(slot);
        sbq.push_back(e);
    endtask

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && sel_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_sel_valid: got idx %0d none %0d, required no pulse", sel_idx, sel_none);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sel_idx", 32'(sel_idx), 32'(e.idx));
                chk("sel_mag", 32'(sel_mag), 32'(e.mag));
                chk("sel_none", 32'(sel_none), 32'(e.none));
                if (!e.none) chk("sel_slot", 32'(sel_slot), 32'(e.slot));
            end
        end
    end

    // Start pulse, then n back-to-back beats from bd/bi, then wait out COMMIT.
    task automatic sweep(input int n);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 19'(bd[i]);
            in_idx   = 8'(bi[i]);
            in_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_support = 1'b1;
        @(posedge clk); #1 clear_support = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #22 rst = 1'b0;
        #1;
        chk("rst_sel_valid", 32'(sel_valid), 0);
        chk("rst_cnt", 32'(support_cnt), 0);
        chk("rst_full", 32'(support_full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rd_idx", 32'(rd_idx), 0);

        // Tie between idx1 and idx3 at |9|: earlier beat wins
        bd = '{3, -9, 5, 9, 0, -2, 7, 1};
        bi = '{0, 1, 2, 3, 4, 5, 6, 7};
        push(1, 9, 1'b0, 0); ecnt = 1;
        sweep(8);
        chk("cnt_after_first", 32'(support_cnt), 32'(ecnt));

        // Same sweep: idx1 now excluded
        push(3, 9, 1'b0, 1); ecnt = 2;
        sweep(8);
        chk("cnt_after_second", 32'(support_cnt), 32'(ecnt));
        rd_slot = 4'd1; #1 chk("rd_slot1", 32'(rd_idx), 3);
        rd_slot = 4'd0; #1 chk("rd_slot0", 32'(rd_idx), 1);
        rd_slot = 4'd2; #1 chk("rd_slot2_empty", 32'(rd_idx), 0);
        rd_slot = 4'd15; #1 chk("rd_slot15_empty", 32'(rd_idx), 0);

        // Most-negative input saturates
        bd[0] = -262144; bi[0] = 5;
        push(5, 262143, 1'b0, 2); ecnt = 3;
        sweep(1);
        chk("cnt_after_sat", 32'(support_cnt), 32'(ecnt));

        pulse_clear();
        ecnt = 0;
        chk("cnt_after_clear", 32'(support_cnt), 0);

        bd[0] = 4; bi[0] = 2;
        push(2, 4, 1'b0, 0); ecnt = 1;
        sweep(1);
        bd[0] = -6; bi[0] = 4;
        push(4, 6, 1'b0, 1); ecnt = 2;
        sweep(1);
        // Every beat excluded: no winner
        bd[0] = 50; bi[0] = 2; bd[1] = -60; bi[1] = 4;
        push(0, 0, 1'b1, 2);
        sweep(2);
        chk("cnt_after_none", 32'(support_cnt), 2);

        // Zero magnitude is still a winner (but never exceeds a zero threshold)
        bd[0] = 0; bi[0] = 10;
`ifdef OMP_SELECTOR_THRESH_EN
        push(10, 0, 1'b1, ecnt);
`else
        push(10, 0, 1'b0, ecnt); ecnt++;
`endif
        sweep(1);
        chk("cnt_after_zero", 32'(support_cnt), 32'(ecnt));

        for (int k = 0; ecnt < 8; k++) begin
            bd[0] = 1; bi[0] = 20 + k;
            push(20 + k, 1, 1'b0, ecnt); ecnt++;
            sweep(1);
        end
        chk("cnt_full", 32'(support_cnt), 8);
        chk("full_flag", 32'(support_full), 1);

        // Start while full is ignored; IDLE beats are ignored
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("full_start_busy", 32'(busy), 0);
        chk("full_start_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_last = 1'b1; in_idx = 8'd99; in_data = 19'd100;
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        chk("idle_beat_cnt", 32'(support_cnt), 8);

        pulse_clear();
        ecnt = 0;
        chk("clear_full_cnt", 32'(support_cnt), 0);
        chk("clear_full_flag", 32'(support_full), 0);

        bd[0] = 2; bi[0] = 7;
        push(7, 2, 1'b0, 0); ecnt = 1;
        sweep(1);
        chk("cnt_before_abort", 32'(support_cnt), 1);

        // Abort after 3 beats; clear wins over a concurrent last beat
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 19'(10 + i); in_idx = 8'(30 + i); in_last = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort_busy_before", 32'(busy), 1);
        clear_support = 1'b1; in_last = 1'b1; in_data = 19'd500; in_idx = 8'd40;
        @(posedge clk); #1;
        clear_support = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cnt", 32'(support_cnt), 0);
        chk("abort_ready", 32'(in_ready), 0);
        ecnt = 0;
        repeat (3) @(posedge clk);
        #1;

        // Early stop: best |9| does not exceed thresh 10
        thresh = 19'd10;
        bd[0] = 3; bd[1] = -9; bd[2] = 5;
        bi[0] = 0; bi[1] = 1; bi[2] = 2;
`ifdef OMP_SELECTOR_THRESH_EN
        push(1, 9, 1'b1, 0);
`else
        push(1, 9, 1'b0, 0); ecnt = 1;
`endif
        sweep(3);
        chk("cnt_after_thresh", 32'(support_cnt), 32'(ecnt));

        // Asynchronous reset mid-sweep
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1; in_data = 19'd77; in_idx = 8'd50;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        in_valid = 1'b0;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(in_ready), 0);
        chk("arst_cnt", 32'(support_cnt), 0);
        chk("arst_sel_idx", 32'(sel_idx), 0);
        chk("arst_sel_mag", 32'(sel_mag), 0);
        chk("arst_sel_none", 32'(sel_none), 0);
        #10 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/omp_atom_selector.md
Name: omp_atom_selector

Overview:
- Parametrised successor to the OMP atom-selection stage.
- Consumes a stream of signed correlation values (VMU dot-product results), one per dictionary atom, and finds the max-magnitude atom per iteration.
- Excludes atoms already in the support set and commits each winner into an internal support list of up to MAX_ITER entries.
- Sits between the VMU sum output and the index/theta register files; the controller drives its start/clear handshakes.

Parameters:
DATA_W, 19, signed correlation width (VMU data width)
IDX_W, 8, atom index width
N_ATOMS, 256, atoms per sweep; in_idx must be < N_ATOMS
MAX_ITER, 8, support-list depth (maximum OMP iterations)
CNT_W, 4, support-count width; must be >= clog2(MAX_ITER+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  pulse: begin a new sweep
clear_support  in  1  pulse: empty support list, abort any sweep
in_valid  in  1  correlation beat valid
in_ready  out  1  selector accepts beat
in_data  in  DATA_W  signed correlation
in_idx  in  IDX_W  atom index of beat
in_last  in  1  final beat of sweep
sel_valid  out  1  one-cycle result pulse
sel_idx  out  IDX_W  winning atom index
sel_mag  out  DATA_W  winning magnitude (unsigned, MSB always 0)
sel_none  out  1  no eligible atom; support unchanged
sel_slot  out  CNT_W  support slot written (count before increment)
support_cnt  out  CNT_W  entries in support list
support_full  out  1  support_cnt == MAX_ITER
rd_slot  in  CNT_W  support readback address
rd_idx  out  IDX_W  support entry at rd_slot (combinational; 0 if rd_slot >= support_cnt)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; support list, running max and count cleared.
- FSM IDLE -> SCAN on start while !support_full. A start while full is ignored; busy stays 0.
- SCAN -> COMMIT on the accepted beat with in_last=1. COMMIT -> IDLE unconditionally after one cycle.
- in_ready = (state == SCAN). A beat is accepted when in_valid && in_ready.
- Magnitude: |in_data|; the most-negative value saturates to 2^(DATA_W-1)-1.
- Exclusion: a beat is ineligible if in_idx matches any valid support entry. This is a parallel compare over MAX_ITER entries, resolved in the same cycle.
- Running max: on entering SCAN, best_valid=0. An eligible beat replaces best if !best_valid or mag > best_mag (strict).
- Ties: the earlier beat wins. A zero-magnitude eligible beat is still a valid winner.
- The in_last beat participates in the comparison before commit.
- COMMIT:
  - sel_valid=1 for exactly one cycle, one cycle after the in_last beat is accepted.
  - If best_valid: write best_idx to slot support_cnt, set sel_slot to the old count, increment support_cnt (visible the cycle after sel_valid).
  - If !best_valid: sel_none=1, sel_idx=0, sel_mag=0, no write.
- sel_idx/sel_mag/sel_slot/sel_none hold their values until the next COMMIT.
- start during SCAN/COMMIT: ignored.
- clear_support: highest priority in any state. Next cycle: count=0, entries invalid, state IDLE, no sel_valid. An aborted sweep's partial result is discarded. A simultaneous start is ignored.
- in_valid in IDLE: not accepted, no effect.
- Asynchronous rst mid-sweep returns every output to its reset value.

Optional Feature:
- Macro OMP_SELECTOR_THRESH_EN.
- Defined:
  - Adds input port thresh (DATA_W, unsigned).
  - In COMMIT, a winner with best_mag <= thresh is treated as none: sel_none=1, no write, sel_idx/sel_mag still report the best candidate.
  - Used for residual-energy early stop.
- Undefined: no thresh port; any eligible winner is committed.

Decomposition:
- Shared package omp_pkg: DATA_W/IDX_W/MAX_ITER defaults, FSM state enum (IDLE/SCAN/COMMIT), saturating-abs function.
- One sub-module, omp_support_cam: MAX_ITER-entry register list with write port, parallel match output, and readback mux.

Test Plan:
- Sweep idx 0..7 with data {3,-9,5,9,0,-2,7,1} -> sel_idx=1, sel_mag=9 (tie with idx3 goes to first), sel_slot=0, support_cnt=1.
- Repeat the same sweep -> idx1 excluded, sel_idx=3, sel_mag=9, support_cnt=2. rd_slot=1 -> rd_idx=3.
- DATA_W=19, beat data=-262144 at idx 5 -> sel_mag=262143, sel_idx=5.
- Support {2,4}; sweep only idx 2,4 -> sel_none=1, support_cnt stays 2.
- Fill to MAX_ITER=8 -> support_full=1; then start -> busy stays 0, in_ready=0.
- clear_support mid-sweep after 3 beats -> next cycle state IDLE, support_cnt=0, no sel_valid. Then start with thresh=10 (THRESH_EN) and max magnitude 9 -> sel_none=1, sel_mag=9.
